// File: rtl/game_pkg.sv
// Shared screen geometry and enemy slot state encoding for the wave controller.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_DYING = 2'd1,
    ST_DEAD  = 2'd2
  } slot_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/enemy_wave_controller_if.sv
// Bullet inputs and per-enemy outputs exchanged between the bullet controller,
// the wave controller and the renderer/score logic.
interface enemy_wave_controller_if #(
  parameter int ENEMY_COUNT  = 4,
  parameter int BULLET_COUNT = 8
);

  logic                                       enable;
  logic [game_pkg::COORD_W*BULLET_COUNT-1:0]  bullet_x_flat;
  logic [game_pkg::COORD_W*BULLET_COUNT-1:0]  bullet_y_flat;
  logic [BULLET_COUNT-1:0]                    bullet_active_flat;
  logic [game_pkg::COORD_W*ENEMY_COUNT-1:0]   enemy_x_flat;
  logic [game_pkg::COORD_W*ENEMY_COUNT-1:0]   enemy_y_flat;
  logic [ENEMY_COUNT-1:0]                     enemy_alive;
  logic [ENEMY_COUNT-1:0]                     enemy_dying;
  logic [ENEMY_COUNT-1:0]                     enemy_hit;
  logic [BULLET_COUNT-1:0]                    bullet_hit;
  logic [15:0]                                kill_count;
  logic                                       tick;

  modport master (
    output enable, bullet_x_flat, bullet_y_flat, bullet_active_flat,
    input  enemy_x_flat, enemy_y_flat, enemy_alive, enemy_dying,
           enemy_hit, bullet_hit, kill_count, tick
  );

  modport slave (
    input  enable, bullet_x_flat, bullet_y_flat, bullet_active_flat,
    output enemy_x_flat, enemy_y_flat, enemy_alive, enemy_dying,
           enemy_hit, bullet_hit, kill_count, tick
  );

endinterface

// File: rtl/enemy_slot.sv
// One enemy slot: ALIVE -> DYING -> DEAD -> ALIVE lifecycle, vertical position
// and the tick-driven explosion/respawn timer.
module enemy_slot
  import game_pkg::*;
#(
  parameter int SPRITE_SIZE   = 32,
  parameter int MOVE_STEP     = 2,
  parameter int DYING_TICKS   = 8,
  parameter int RESPAWN_TICKS = 64
) (
  input  logic               clk25,
  input  logic               reset,
  input  logic               i_tick,
  input  logic               i_kill,
  output logic [COORD_W-1:0] o_y,
  output slot_state_t        o_state
);

  localparam int TIMER_W = $clog2(max2(DYING_TICKS, RESPAWN_TICKS) + 1);
  localparam logic [TIMER_W-1:0] DYING_INIT   = TIMER_W'(DYING_TICKS - 1);
  localparam logic [TIMER_W-1:0] RESPAWN_INIT = TIMER_W'(RESPAWN_TICKS - 1);
  localparam logic [COORD_W-1:0] Y_LIMIT      = COORD_W'(SCREEN_H - SPRITE_SIZE);
  localparam logic [COORD_W-1:0] Y_STEP       = COORD_W'(MOVE_STEP);

  slot_state_t        r_state, w_state_next;
  logic [COORD_W-1:0] r_y, w_y_next;
  logic [TIMER_W-1:0] r_timer, w_timer_next;

  always_ff @(posedge clk25) begin
    if (reset) begin
      r_state <= ST_ALIVE;
      r_y     <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_y     <= w_y_next;
      r_timer <= w_timer_next;
    end
  end

  // A kill outranks a coincident movement tick; y stays frozen until respawn.
  always_comb begin
    w_state_next = r_state;
    w_y_next     = r_y;
    w_timer_next = r_timer;
    case (r_state)
      ST_ALIVE: begin
        if (i_kill) begin
          w_state_next = ST_DYING;
          w_timer_next = DYING_INIT;
        end else if (i_tick) begin
          w_y_next = (r_y >= Y_LIMIT) ? '0 : r_y + Y_STEP;
        end
      end
      ST_DYING: begin
        if (i_tick) begin
          if (r_timer == '0) begin
            w_state_next = ST_DEAD;
            w_timer_next = RESPAWN_INIT;
          end else begin
            w_timer_next = r_timer - TIMER_W'(1);
          end
        end
      end
      ST_DEAD: begin
        if (i_tick) begin
          if (r_timer == '0) begin
            w_state_next = ST_ALIVE;
            w_y_next     = '0;
          end else begin
            w_timer_next = r_timer - TIMER_W'(1);
          end
        end
      end
      default: w_state_next = ST_ALIVE;
    endcase
  end

  assign o_y     = r_y;
  assign o_state = r_state;

endmodule

// File: rtl/enemy_wave_controller.sv
// Enemy wave manager: movement tick generator, bullet/enemy hit matrix with
// two-level priority arbitration, per-slot lifecycles and a saturating kill counter.
module enemy_wave_controller
  import game_pkg::*;
#(
  parameter int ENEMY_COUNT   = 4,
  parameter int BULLET_COUNT  = 8,
  parameter int SPRITE_SIZE   = 32,
  parameter int MOVE_PERIOD   = 524288,
  parameter int MOVE_STEP     = 2,
  parameter int X_BASE        = 200,
  parameter int X_STEP        = 50,
  parameter int DYING_TICKS   = 8,
  parameter int RESPAWN_TICKS = 64
) (
  input  logic                     clk25,
  input  logic                     reset,
  enemy_wave_controller_if.slave   bus
);

  localparam int EC    = ENEMY_COUNT;
  localparam int BC    = BULLET_COUNT;
  localparam int C11   = COORD_W + 1;
  localparam int CNT_W = $clog2(MOVE_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_PERIOD - 1);
  localparam logic [C11-1:0]   SIZE11   = C11'(SPRITE_SIZE);

  logic [CNT_W-1:0]      r_tick_cnt;
  logic                  r_tick;
  logic                  w_tick_fire;
  logic [EC-1:0]         r_enemy_hit;
  logic [BC-1:0]         r_bullet_hit;
  logic [15:0]           r_kill_count;

  logic [COORD_W-1:0]    w_slot_y [EC];
  slot_state_t           w_slot_state [EC];
  logic [EC-1:0]         w_alive, w_dying, w_kill;
  logic [COORD_W*EC-1:0] w_enemy_x_flat, w_enemy_y_flat;
  logic [C11-1:0]        w_ey [EC];
  logic [C11-1:0]        w_ey_hi [EC];
  logic [C11-1:0]        w_bx [BC];
  logic [C11-1:0]        w_by [BC];
  logic [EC-1:0]         w_overlap [BC];
  logic [EC-1:0]         w_target [BC];
  logic [BC-1:0]         w_cand [EC];
  logic [BC-1:0]         w_grant [EC];
  logic [EC-1:0]         w_grant_t [BC];
  logic [BC-1:0]         w_bullet_hit;
  logic [4:0]            w_kill_pop;
  logic [16:0]           w_kill_sum;

  assign w_tick_fire = bus.enable && (r_tick_cnt == CNT_LAST);

  always_ff @(posedge clk25) begin
    if (reset) begin
      r_tick_cnt   <= '0;
      r_tick       <= 1'b0;
      r_enemy_hit  <= '0;
      r_bullet_hit <= '0;
      r_kill_count <= '0;
    end else begin
      if (bus.enable) begin
        r_tick_cnt <= w_tick_fire ? '0 : r_tick_cnt + CNT_W'(1);
      end
      r_tick       <= w_tick_fire;
      r_enemy_hit  <= w_kill;
      r_bullet_hit <= w_bullet_hit;
      r_kill_count <= w_kill_sum[16] ? 16'hFFFF : w_kill_sum[15:0];
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < EC; gi++) begin : g_slot
      localparam logic [C11-1:0] X_LO = C11'(X_BASE + gi * X_STEP);
      localparam logic [C11-1:0] X_HI = X_LO + SIZE11;

      enemy_slot #(
        .SPRITE_SIZE   (SPRITE_SIZE),
        .MOVE_STEP     (MOVE_STEP),
        .DYING_TICKS   (DYING_TICKS),
        .RESPAWN_TICKS (RESPAWN_TICKS)
      ) u_slot (
        .clk25   (clk25),
        .reset   (reset),
        .i_tick  (w_tick_fire),
        .i_kill  (w_kill[gi]),
        .o_y     (w_slot_y[gi]),
        .o_state (w_slot_state[gi])
      );

      assign w_alive[gi] = (w_slot_state[gi] == ST_ALIVE);
      assign w_dying[gi] = (w_slot_state[gi] == ST_DYING);
      assign w_ey[gi]    = {1'b0, w_slot_y[gi]};
      assign w_ey_hi[gi] = w_ey[gi] + SIZE11;
      assign w_enemy_x_flat[gi*COORD_W +: COORD_W] = X_LO[COORD_W-1:0];
      assign w_enemy_y_flat[gi*COORD_W +: COORD_W] = w_slot_y[gi];

      for (gj = 0; gj < BC; gj++) begin : g_hit
        assign w_overlap[gj][gi] = bus.bullet_active_flat[gj] & w_alive[gi]
                                 & (w_bx[gj] >= X_LO) & (w_bx[gj] < X_HI)
                                 & (w_by[gj] >= w_ey[gi]) & (w_by[gj] < w_ey_hi[gi]);
        assign w_cand[gi][gj]    = w_target[gj][gi];
        assign w_grant_t[gj][gi] = w_grant[gi][gj];
      end

      // Second level: each enemy keeps only the lowest bullet aimed at it.
      assign w_grant[gi] = w_cand[gi] & (~w_cand[gi] + BC'(1));
      assign w_kill[gi]  = |w_grant[gi];
    end

    for (gj = 0; gj < BC; gj++) begin : g_bullet
      assign w_bx[gj] = {1'b0, bus.bullet_x_flat[gj*COORD_W +: COORD_W]};
      assign w_by[gj] = {1'b0, bus.bullet_y_flat[gj*COORD_W +: COORD_W]};
      // First level: a bullet only ever targets its lowest overlapping enemy.
      assign w_target[gj]     = w_overlap[gj] & (~w_overlap[gj] + EC'(1));
      assign w_bullet_hit[gj] = |w_grant_t[gj];
    end
  endgenerate

  always_comb begin
    w_kill_pop = '0;
    for (int i = 0; i < EC; i++) begin
      w_kill_pop = w_kill_pop + 5'(w_kill[i]);
    end
  end

  assign w_kill_sum = {1'b0, r_kill_count} + 17'(w_kill_pop);

  assign bus.enemy_x_flat = w_enemy_x_flat;
  assign bus.enemy_y_flat = w_enemy_y_flat;
  assign bus.enemy_alive  = w_alive;
  assign bus.enemy_dying  = w_dying;
  assign bus.enemy_hit    = r_enemy_hit;
  assign bus.bullet_hit   = r_bullet_hit;
  assign bus.kill_count   = r_kill_count;
  assign bus.tick         = r_tick;

endmodule

// File: tb/tb_enemy_wave_controller.sv
// Randomised and directed checks of the enemy wave controller against a
// cycle-level behavioural model of the game rules.
module tb_enemy_wave_controller;
  import game_pkg::*;

  localparam int EC = 4, BC = 8, SS = 32, MP = 4, MS = 2;
  localparam int XB = 200, XS = 50, DT = 2, RT = 3;
  localparam int M_ALIVE = 0, M_DYING = 1, M_DEAD = 2;

  logic clk25 = 1'b0;
  logic reset = 1'b0;
  always #20 clk25 = ~clk25;

  enemy_wave_controller_if #(.ENEMY_COUNT(EC), .BULLET_COUNT(BC)) bus();

  enemy_wave_controller #(
    .ENEMY_COUNT(EC), .BULLET_COUNT(BC), .SPRITE_SIZE(SS), .MOVE_PERIOD(MP),
    .MOVE_STEP(MS), .X_BASE(XB), .X_STEP(XS), .DYING_TICKS(DT), .RESPAWN_TICKS(RT)
  ) dut (
    .clk25 (clk25),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Model state: life stage, y, ticks left in the current stage.
  int m_y [EC];
  int m_st [EC];
  int m_left [EC];
  int m_en_cycles;
  int m_kills;
  logic [EC-1:0]    m_hit;
  logic [BC-1:0]    m_bhit;
  logic             m_tick;
  logic [10*EC-1:0] exp_y, exp_x;
  logic [EC-1:0]    exp_alive, exp_dying;

  function automatic bit covers(input int i, input int bx, input int by);
    int xl = XB + i * XS;
    return (bx >= xl) && (bx < xl + SS) && (by >= m_y[i]) && (by < m_y[i] + SS);
  endfunction

  task automatic set_bullet(input int j, input int x, input int y);
    bus.bullet_x_flat[j*10 +: 10] = 10'(x);
    bus.bullet_y_flat[j*10 +: 10] = 10'(y);
    bus.bullet_active_flat[j]     = 1'b1;
  endtask

  task automatic clear_bullets();
    bus.bullet_active_flat = '0;
    bus.bullet_x_flat      = '0;
    bus.bullet_y_flat      = '0;
  endtask

  // Advance DUT and model by one clock edge with the inputs currently applied.
  task automatic step(input bit rst);
    int tgt [BC];
    int pop;
    bit fire;
    reset  = rst;
    m_hit  = '0;
    m_bhit = '0;
    m_tick = 1'b0;
    if (rst) begin
      for (int i = 0; i < EC; i++) begin
        m_y[i] = 0; m_st[i] = M_ALIVE; m_left[i] = 0;
      end
      m_en_cycles = 0;
      m_kills = 0;
    end else begin
      for (int j = 0; j < BC; j++) begin
        tgt[j] = -1;
        if (bus.bullet_active_flat[j]) begin
          for (int i = 0; i < EC; i++) begin
            if (tgt[j] < 0 && m_st[i] == M_ALIVE &&
                covers(i, int'(bus.bullet_x_flat[j*10 +: 10]), int'(bus.bullet_y_flat[j*10 +: 10])))
              tgt[j] = i;
          end
        end
      end
      for (int i = 0; i < EC; i++)
        for (int j = 0; j < BC; j++)
          if (tgt[j] == i && !m_hit[i]) begin
            m_hit[i] = 1'b1;
            m_bhit[j] = 1'b1;
          end
      fire = 1'b0;
      if (bus.enable) begin
        m_en_cycles++;
        fire = ((m_en_cycles % MP) == 0);
      end
      m_tick = fire;
      pop = 0;
      for (int i = 0; i < EC; i++) begin
        if (m_hit[i]) begin
          pop++;
          m_st[i] = M_DYING;
          m_left[i] = DT;
        end else if (fire) begin
          if (m_st[i] == M_ALIVE) begin
            m_y[i] = (m_y[i] >= 480 - SS) ? 0 : m_y[i] + MS;
          end else if (m_st[i] == M_DYING) begin
            m_left[i]--;
            if (m_left[i] == 0) begin m_st[i] = M_DEAD; m_left[i] = RT; end
          end else begin
            m_left[i]--;
            if (m_left[i] == 0) begin m_st[i] = M_ALIVE; m_y[i] = 0; end
          end
        end
      end
      m_kills = (m_kills + pop > 65535) ? 65535 : m_kills + pop;
    end
    for (int i = 0; i < EC; i++) begin
      exp_y[i*10 +: 10] = 10'(m_y[i]);
      exp_alive[i] = (m_st[i] == M_ALIVE);
      exp_dying[i] = (m_st[i] == M_DYING);
    end
    @(posedge clk25);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0;
    clear_bullets();
    step(1'b1);
    checks++; if (bus.enemy_x_flat !== exp_x) begin errors++; $display("FAIL reset_x got=%h exp=%h", bus.enemy_x_flat, exp_x); end
    checks++; if (bus.enemy_y_flat !== exp_y) begin errors++; $display("FAIL reset_y got=%h exp=%h", bus.enemy_y_flat, exp_y); end
    checks++; if (bus.enemy_alive !== 4'hF) begin errors++; $display("FAIL reset_alive got=%b exp=1111", bus.enemy_alive); end
    checks++; if (bus.enemy_dying !== 4'h0) begin errors++; $display("FAIL reset_dying got=%b exp=0000", bus.enemy_dying); end
    checks++; if (bus.enemy_hit !== 4'h0) begin errors++; $display("FAIL reset_hit got=%b exp=0000", bus.enemy_hit); end
    checks++; if (bus.bullet_hit !== 8'h00) begin errors++; $display("FAIL reset_bhit got=%b exp=0", bus.bullet_hit); end
    checks++; if (bus.kill_count !== 16'd0) begin errors++; $display("FAIL reset_kills got=%0d exp=0", bus.kill_count); end
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", bus.tick); end
    $display("test_reset done");
  endtask

  task automatic test_movement();
    logic [9:0] prev_y0;
    bit saw_wrap = 1'b0;
    clear_bullets();
    step(1'b1);
    bus.enable = 1'b1;
    prev_y0 = bus.enemy_y_flat[9:0];
    for (int c = 0; c < 230 * MP; c++) begin
      step(1'b0);
      checks++; if (bus.enemy_y_flat !== exp_y) begin errors++; $display("FAIL move_y cyc=%0d got=%h exp=%h", c, bus.enemy_y_flat, exp_y); end
      checks++; if (bus.tick !== m_tick) begin errors++; $display("FAIL move_tick cyc=%0d got=%b exp=%b", c, bus.tick, m_tick); end
      if (prev_y0 == 10'd448 && bus.enemy_y_flat[9:0] == 10'd0) saw_wrap = 1'b1;
      prev_y0 = bus.enemy_y_flat[9:0];
    end
    checks++; if (saw_wrap !== 1'b1) begin errors++; $display("FAIL move_wrap got=%b exp=1", saw_wrap); end
    $display("test_movement done y0=%0d", bus.enemy_y_flat[9:0]);
  endtask

  task automatic test_single_hit();
    step(1'b1);
    bus.enable = 1'b1;
    set_bullet(0, 205, 10);
    step(1'b0);
    checks++; if (bus.enemy_hit !== 4'b0001) begin errors++; $display("FAIL single_hit got=%b exp=0001", bus.enemy_hit); end
    checks++; if (bus.bullet_hit !== m_bhit) begin errors++; $display("FAIL single_bhit got=%b exp=%b", bus.bullet_hit, m_bhit); end
    checks++; if (bus.enemy_dying !== exp_dying) begin errors++; $display("FAIL single_dying got=%b exp=%b", bus.enemy_dying, exp_dying); end
    checks++; if (bus.enemy_alive !== exp_alive) begin errors++; $display("FAIL single_alive got=%b exp=%b", bus.enemy_alive, exp_alive); end
    checks++; if (bus.kill_count !== 16'd1) begin errors++; $display("FAIL single_kills got=%0d exp=1", bus.kill_count); end
    clear_bullets();
    step(1'b0);
    checks++; if (bus.enemy_hit !== 4'b0000) begin errors++; $display("FAIL single_pulse got=%b exp=0000", bus.enemy_hit); end
    $display("test_single_hit done");
  endtask

  task automatic test_double_bullet();
    step(1'b1);
    bus.enable = 1'b1;
    set_bullet(0, 205, 5);
    set_bullet(1, 205, 5);
    for (int k = 0; k < 2; k++) begin
      step(1'b0);
      checks++; if (bus.bullet_hit !== m_bhit) begin errors++; $display("FAIL double_bhit k=%0d got=%b exp=%b", k, bus.bullet_hit, m_bhit); end
      checks++; if (bus.enemy_hit !== m_hit) begin errors++; $display("FAIL double_hit k=%0d got=%b exp=%b", k, bus.enemy_hit, m_hit); end
      checks++; if (bus.kill_count !== 16'(m_kills)) begin errors++; $display("FAIL double_kills k=%0d got=%0d exp=%0d", k, bus.kill_count, m_kills); end
    end
    clear_bullets();
    $display("test_double_bullet done kills=%0d", bus.kill_count);
  endtask

  task automatic test_boundary();
    int bx_tab [7] = '{231, 232, 199, 200, 381, 205, 250};
    int by_tab [7] = '{5,   5,   5,   31,  0,   32,  31};
    for (int t = 0; t < 7; t++) begin
      clear_bullets();
      step(1'b1);
      bus.enable = 1'b1;
      set_bullet(3, bx_tab[t], by_tab[t]);
      step(1'b0);
      checks++; if (bus.enemy_hit !== m_hit) begin errors++; $display("FAIL bound_hit x=%0d y=%0d got=%b exp=%b", bx_tab[t], by_tab[t], bus.enemy_hit, m_hit); end
      checks++; if (bus.bullet_hit !== m_bhit) begin errors++; $display("FAIL bound_bhit x=%0d y=%0d got=%b exp=%b", bx_tab[t], by_tab[t], bus.bullet_hit, m_bhit); end
      $display("boundary x=%0d y=%0d hit=%b", bx_tab[t], by_tab[t], bus.enemy_hit);
    end
    clear_bullets();
  endtask

  task automatic test_lifecycle();
    clear_bullets();
    step(1'b1);
    bus.enable = 1'b1;
    repeat (9) step(1'b0);
    set_bullet(0, 210, m_y[0] + 4);
    step(1'b0);
    clear_bullets();
    for (int c = 0; c < (DT + RT + 2) * MP; c++) begin
      checks++; if (bus.enemy_alive !== exp_alive || bus.enemy_dying !== exp_dying) begin
        errors++; $display("FAIL life_state cyc=%0d got=%b/%b exp=%b/%b", c, bus.enemy_alive, bus.enemy_dying, exp_alive, exp_dying);
      end
      checks++; if (bus.enemy_y_flat !== exp_y) begin errors++; $display("FAIL life_y cyc=%0d got=%h exp=%h", c, bus.enemy_y_flat, exp_y); end
      step(1'b0);
    end
    checks++; if (bus.enemy_alive[0] !== 1'b1) begin errors++; $display("FAIL life_respawn got=%b exp=1", bus.enemy_alive[0]); end
    $display("test_lifecycle done y0=%0d", bus.enemy_y_flat[9:0]);
  endtask

  task automatic test_enable_freeze();
    clear_bullets();
    step(1'b1);
    bus.enable = 1'b1;
    repeat (6) step(1'b0);
    bus.enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) set_bullet(2, 305, m_y[2] + 3);
      if (c == 5) clear_bullets();
      step(1'b0);
      checks++; if (bus.enemy_y_flat !== exp_y || bus.tick !== m_tick) begin
        errors++; $display("FAIL freeze_move cyc=%0d got=%h/%b exp=%h/%b", c, bus.enemy_y_flat, bus.tick, exp_y, m_tick);
      end
      checks++; if (bus.enemy_hit !== m_hit || bus.kill_count !== 16'(m_kills)) begin
        errors++; $display("FAIL freeze_hit cyc=%0d got=%b/%0d exp=%b/%0d", c, bus.enemy_hit, bus.kill_count, m_hit, m_kills);
      end
    end
    bus.enable = 1'b1;
    $display("test_enable_freeze done kills=%0d", bus.kill_count);
  endtask

  task automatic test_reset_dying_tick();
    int budget = 0;
    clear_bullets();
    step(1'b1);
    bus.enable = 1'b1;
    set_bullet(0, 215, 8);
    step(1'b0);
    clear_bullets();
    while ((m_en_cycles % MP) != MP - 1 && budget < 20) begin
      step(1'b0);
      budget++;
    end
    checks++; if (bus.enemy_dying[0] !== 1'b1) begin errors++; $display("FAIL rst_pre_dying got=%b exp=1", bus.enemy_dying[0]); end
    step(1'b1);
    checks++; if (bus.enemy_alive !== 4'hF || bus.enemy_dying !== 4'h0) begin
      errors++; $display("FAIL rst_state got=%b/%b exp=1111/0000", bus.enemy_alive, bus.enemy_dying);
    end
    checks++; if (bus.enemy_hit !== 4'h0 || bus.bullet_hit !== 8'h00 || bus.tick !== 1'b0) begin
      errors++; $display("FAIL rst_pulses got=%b/%b/%b exp=0/0/0", bus.enemy_hit, bus.bullet_hit, bus.tick);
    end
    checks++; if (bus.kill_count !== 16'd0 || bus.enemy_y_flat !== '0) begin
      errors++; $display("FAIL rst_regs got=%0d/%h exp=0/0", bus.kill_count, bus.enemy_y_flat);
    end
    $display("test_reset_dying_tick done");
  endtask

  task automatic test_random();
    int k, bx, by;
    clear_bullets();
    step(1'b1);
    for (int c = 0; c < 3000; c++) begin
      bus.enable = ($urandom_range(0, 9) != 0);
      clear_bullets();
      for (int j = 0; j < BC; j++) begin
        if ($urandom_range(0, 2) == 0) begin
          k  = int'($urandom_range(0, EC - 1));
          bx = XB + k * XS + int'($urandom_range(0, 40)) - 4;
          by = m_y[k] + int'($urandom_range(0, 40)) - 4;
          set_bullet(j, bx, (by < 0) ? 0 : by);
        end
      end
      step($urandom_range(0, 499) == 0);
      checks++; if (bus.enemy_y_flat !== exp_y) begin errors++; $display("FAIL rnd_y cyc=%0d got=%h exp=%h", c, bus.enemy_y_flat, exp_y); end
      checks++; if (bus.enemy_alive !== exp_alive || bus.enemy_dying !== exp_dying) begin
        errors++; $display("FAIL rnd_state cyc=%0d got=%b/%b exp=%b/%b", c, bus.enemy_alive, bus.enemy_dying, exp_alive, exp_dying);
      end
      checks++; if (bus.enemy_hit !== m_hit) begin errors++; $display("FAIL rnd_hit cyc=%0d got=%b exp=%b", c, bus.enemy_hit, m_hit); end
      checks++; if (bus.bullet_hit !== m_bhit) begin errors++; $display("FAIL rnd_bhit cyc=%0d got=%b exp=%b", c, bus.bullet_hit, m_bhit); end
      checks++; if (bus.kill_count !== 16'(m_kills)) begin errors++; $display("FAIL rnd_kills cyc=%0d got=%0d exp=%0d", c, bus.kill_count, m_kills); end
      checks++; if (bus.tick !== m_tick) begin errors++; $display("FAIL rnd_tick cyc=%0d got=%b exp=%b", c, bus.tick, m_tick); end
    end
    $display("test_random done kills=%0d", bus.kill_count);
  endtask

  initial begin
    for (int i = 0; i < EC; i++) exp_x[i*10 +: 10] = 10'(XB + i * XS);
    bus.enable = 1'b0;
    clear_bullets();
    @(posedge clk25);
    #1;
    test_reset();
    test_movement();
    test_single_hit();
    test_double_bullet();
    test_boundary();
    test_lifecycle();
    test_enable_freeze();
    test_reset_dying_tick();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
